// File: rtl/psk_window_correlator_pkg.sv
// Constants shared by the window correlator and its window dispatcher:
// local-oscillator phase encoding and window length.
package psk_window_correlator_pkg;

  localparam int WIN_LOG2 = 11;

  localparam logic [1:0] PH_COS_P = 2'd0;
  localparam logic [1:0] PH_SIN_P = 2'd1;
  localparam logic [1:0] PH_COS_N = 2'd2;
  localparam logic [1:0] PH_SIN_N = 2'd3;

endpackage

// File: rtl/psk_lo_mixer.sv
// fs/4 quadrature mixer: a free-running 2-bit phase counter that selects
// which accumulator receives +s or -s on each clock.
module psk_lo_mixer
  import psk_window_correlator_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    win_rst,
  input  logic signed [IN_W-1:0]  sample,
  output logic signed [ACC_W-1:0] di,
  output logic signed [ACC_W-1:0] dq
);

  logic [1:0]              ph_r;
  logic signed [ACC_W-1:0] s_ext_s;

  // Phase counter, realigned so the cycle after a window boundary is phase 0.
  always_ff @(posedge clk) begin
    if (rst_in || win_rst) begin
      ph_r <= 2'd0;
    end else begin
      ph_r <= ph_r + 2'd1;
    end
  end

  // Widen before negating so that -(-2^(IN_W-1)) is exact.
  assign s_ext_s = {{(ACC_W-IN_W){sample[IN_W-1]}}, sample};

  // Route the widened sample to I or Q with the sign of the current LO phase.
  always_comb begin
    di = '0;
    dq = '0;
    case (ph_r)
      PH_COS_P: di = s_ext_s;
      PH_SIN_P: dq = s_ext_s;
      PH_COS_N: di = -s_ext_s;
      PH_SIN_N: dq = -s_ext_s;
      default: begin
        di = '0;
        dq = '0;
      end
    endcase
  end

endmodule

// File: rtl/psk_window_correlator.sv
// Windowed I/Q correlator: accumulates the mixed sample stream per window,
// snapshots at each boundary and publishes I, Q, |I|+|Q| on valid/ready.
module psk_window_correlator
  import psk_window_correlator_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic signed [IN_W-1:0]  sample,
  input  logic                    win_rst,
  input  logic                    win_stb,
  output logic signed [ACC_W-1:0] out_i,
  output logic signed [ACC_W-1:0] out_q,
  output logic [ACC_W:0]          out_mag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  logic signed [ACC_W-1:0] di_s, dq_s;
  logic signed [ACC_W-1:0] sum_i_s, sum_q_s;
  logic signed [ACC_W-1:0] acc_i_r, acc_q_r;
  logic signed [ACC_W-1:0] snap_i_r, snap_q_r;
  logic [ACC_W:0]          mag_s;
  logic                    load_s;

  // |v| in one extra bit so the most negative value maps onto 2^(ACC_W-1).
  function automatic logic [ACC_W:0] mag_of(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W:0] w;
    w = {v[ACC_W-1], v};
    if (w[ACC_W]) begin
      mag_of = -w;
    end else begin
      mag_of = w;
    end
  endfunction

  psk_lo_mixer #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_mixer (
    .clk     (clk),
    .rst_in  (rst_in),
    .win_rst (win_rst),
    .sample  (sample),
    .di      (di_s),
    .dq      (dq_s)
  );

  assign sum_i_s = acc_i_r + di_s;
  assign sum_q_s = acc_q_r + dq_s;
  assign mag_s   = mag_of(snap_i_r) + mag_of(snap_q_r);
  // A publish lands unless an unaccepted result is still being presented.
  assign load_s  = win_stb && (!out_valid || out_ready);

  // Accumulate; the boundary sample closes its window into the snapshot.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      acc_i_r  <= '0;
      acc_q_r  <= '0;
      snap_i_r <= '0;
      snap_q_r <= '0;
    end else if (win_rst) begin
      acc_i_r  <= '0;
      acc_q_r  <= '0;
      snap_i_r <= sum_i_s;
      snap_q_r <= sum_q_s;
    end else begin
      acc_i_r  <= sum_i_s;
      acc_q_r  <= sum_q_s;
    end
  end

  // Output register and handshake; stb reads the pre-boundary snapshot.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      out_i     <= '0;
      out_q     <= '0;
      out_mag   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (load_s) begin
      out_i     <= snap_i_r;
      out_q     <= snap_q_r;
      out_mag   <= mag_s;
      out_valid <= 1'b1;
    end else if (win_stb) begin
      overrun   <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psk_window_correlator.sv
// Randomised/directed bench with a window-level reference model feeding a
// scoreboard queue; a negedge monitor checks every accepted result.
module tb_psk_window_correlator;

  localparam int IN_W  = 8;
  localparam int ACC_W = 20;

  typedef struct {
    longint i;
    longint q;
    longint m;
  } res_t;

  logic                    clk = 1'b0;
  logic                    rst_in = 1'b1;
  logic signed [IN_W-1:0]  sample = '0;
  logic                    win_rst = 1'b0;
  logic                    win_stb = 1'b0;
  logic                    out_ready = 1'b0;
  logic signed [ACC_W-1:0] out_i, out_q;
  logic [ACC_W:0]          out_mag;
  logic                    out_valid, overrun;

  int     n_tests = 0;
  int     n_fail  = 0;
  bit     started = 1'b0;
  bit     stb_pend = 1'b0;

  // reference model state
  longint wl[$];
  longint sn_i = 0, sn_q = 0;
  bit     m_valid = 1'b0, m_ovr = 1'b0;
  res_t   exp_q[$];

  psk_window_correlator #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_in    (rst_in),
    .sample    (sample),
    .win_rst   (win_rst),
    .win_stb   (win_stb),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_mag   (out_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint wrap_acc(input longint v);
    logic signed [ACC_W-1:0] t;
    t = v[ACC_W-1:0];
    return longint'(t);
  endfunction

  function automatic longint absl(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Window sums: sample k after the boundary is weighted by cos/sin of k*pi/2.
  task automatic window_sums(output longint si, output longint sq);
    longint ai = 0, aq = 0;
    foreach (wl[k]) begin
      case (k % 4)
        0: ai += wl[k];
        1: aq += wl[k];
        2: ai -= wl[k];
        default: aq -= wl[k];
      endcase
    end
    si = wrap_acc(ai);
    sq = wrap_acc(aq);
  endtask

  // Reference model: applies each clock edge's inputs at the window level.
  initial forever begin
    @(posedge clk);
    if (rst_in) begin
      wl.delete();
      exp_q.delete();
      sn_i = 0; sn_q = 0;
      m_valid = 1'b0; m_ovr = 1'b0;
      started = 1'b1;
    end else begin
      wl.push_back(longint'(sample));
      if (win_stb) begin
        if (!m_valid || out_ready) begin
          exp_q.push_back('{i: sn_i, q: sn_q, m: absl(sn_i) + absl(sn_q)});
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (win_rst) begin
        window_sums(sn_i, sn_q);
        wl.delete();
      end
    end
  end

  // Monitor: flags and every transferred result against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (started) begin
      check("out_valid", out_valid, m_valid);
      check("overrun", overrun, m_ovr);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("sb_out_i", out_i, e.i);
          check("sb_out_q", out_q, e.q);
          check("sb_out_mag", out_mag, e.m);
        end
      end
    end
  end

  task automatic cyc(input logic signed [IN_W-1:0] s, input logic wr, input logic ws,
                     input logic rdy, input logic r);
    @(posedge clk);
    #1;
    sample    = s;
    win_rst   = wr;
    win_stb   = ws;
    out_ready = rdy;
    rst_in    = r;
  endtask

  function automatic logic signed [IN_W-1:0] pattern(input int mode, input int i);
    logic signed [IN_W-1:0] v;
    case (mode)
      0: v = 8'sd10;
      1: v = (i % 4 == 0) ? 8'sd10 : ((i % 4 == 2) ? -8'sd10 : 8'sd0);
      2: v = (i % 4 == 1) ? 8'sd127 : ((i % 4 == 3) ? 8'sh80 : 8'sd0);
      default: v = IN_W'($urandom);
    endcase
    return v;
  endfunction

  task automatic do_reset();
    cyc(8'sd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(8'sd0, 1'b0, 1'b0, 1'b0, 1'b1);
    stb_pend = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_i", out_i, 0);
    check("rst_q", out_q, 0);
    check("rst_mag", out_mag, 0);
    check("rst_overrun", overrun, 0);
  endtask

  // rdy_mode: 0 never, 1 always, 2 only at i==100, 3 only at i==0.
  // With chk, the result published at i==0 is checked against ei/eq/em.
  task automatic run_window(input int n, input int mode, input int rdy_mode, input int rst_at,
                            input bit chk, input longint ei, input longint eq,
                            input longint em, input int eo);
    for (int i = 0; i < n; i++) begin
      logic rdy;
      case (rdy_mode)
        0: rdy = 1'b0;
        1: rdy = 1'b1;
        2: rdy = (i == 100);
        default: rdy = (i == 0);
      endcase
      cyc(pattern(mode, i), (i == n - 1), stb_pend, rdy, (i == rst_at));
      stb_pend = (i == n - 1);
      if (chk && i == 1) begin
        @(negedge clk);
        check("pub_valid", out_valid, 1);
        check("pub_i", out_i, ei);
        check("pub_q", out_q, eq);
        check("pub_mag", out_mag, em);
        check("pub_overrun", overrun, eo);
      end
      if (chk && rdy_mode == 1 && i == 2) begin
        @(negedge clk);
        check("pulse_valid", out_valid, 0);
      end
      if (rdy_mode == 2 && i == 101) begin
        @(negedge clk);
        check("drain_valid", out_valid, 0);
        check("drain_overrun", overrun, 1);
      end
      if (rst_at >= 0 && i == rst_at + 1) begin
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_i", out_i, 0);
        check("mid_rst_q", out_q, 0);
        check("mid_rst_mag", out_mag, 0);
        check("mid_rst_overrun", overrun, 0);
      end
    end
  endtask

  initial begin
    do_reset();
    // constant input cancels over a whole window
    run_window(2048, 0, 1, -1, 1'b0, 0, 0, 0, 0);
    run_window(2048, 0, 1, -1, 1'b1, 0, 0, 0, 0);
    run_window(2048, 1, 1, -1, 1'b1, 0, 0, 0, 0);
    run_window(2048, 2, 1, -1, 1'b1, 10240, 0, 10240, 0);
    // backpressure: hold first, drop second, then one transfer
    run_window(2048, 1, 0, -1, 1'b1, 0, 130560, 130560, 0);
    run_window(2048, 0, 2, -1, 1'b1, 0, 130560, 130560, 1);
    // load concurrent with a transfer
    do_reset();
    run_window(2048, 1, 0, -1, 1'b0, 0, 0, 0, 0);
    run_window(2048, 2, 0, -1, 1'b1, 10240, 0, 10240, 0);
    run_window(2048, 0, 3, -1, 1'b1, 0, 130560, 130560, 0);
    // reset mid-window while a result is pending
    run_window(2048, 3, 0, 1000, 1'b0, 0, 0, 0, 0);
    run_window(2048, 1, 1, -1, 1'b0, 0, 0, 0, 0);
    run_window(2048, 1, 1, -1, 1'b1, 10240, 0, 10240, 0);
    // random traffic, including stray stb and coincident rst/stb
    for (int c = 0; c < 4000; c++) begin
      logic wr, ws, rdy, r;
      r   = ($urandom_range(0, 599) == 0);
      wr  = ($urandom_range(0, 24) == 0);
      ws  = stb_pend ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      cyc(IN_W'($urandom), wr, ws, rdy, r);
      stb_pend = wr;
    end
    for (int c = 0; c < 4; c++) begin
      cyc(8'sd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
